bcd2bin_seq: RTL and testbench

Sequential BCD-to-binary converter using iterative reverse double-dabble (shift right, then subtract 3 from every digit ≥ 8). It converts a packed multi-digit BCD value, such as a setpoint entered on the board's digit switches or received as BCD from the host, into a plain binary value for the sensor datapath. It is the inverse of the binary-to-BCD display conversion. It uses one shift/correct step per clock, a start/done handshake, and flags non-decimal digits.

---
 rtl/bcd2bin_seq.sv | 155 +++++++++++++++
 tb/tb_bcd2bin_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential packed-BCD to binary converter.
//
// Reverse double-dabble, one step per clock: the work register starts as {BCD, zeros}.
// Each step shifts it right by one. Then every BCD nibble that reads 8 or more has 3
// subtracted. After BIN_W steps the low BIN_W bits hold the binary value.
//
// Parameters
//   DIGITS  number of packed BCD digits on iBCD
//   BIN_W   result width and step count; 2**BIN_W must exceed 10**DIGITS - 1
// Ports
//   iCLK_50  system clock
//   iRST_N   asynchronous active-low reset
//   iSTART   conversion request, sampled only while idle
//   iBCD     packed BCD input, [3:0] is the ones digit
//   oBIN     binary result, held between conversions
//   oDONE    one-cycle pulse when oBIN/oERR are updated
//   oBUSY    high whenever the converter is not idle
//   oERR     last accepted iBCD contained a digit above 9
module bcd2bin_seq #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  iCLK_50,
  input  logic                  iRST_N,
  input  logic                  iSTART,
  input  logic [4*DIGITS-1:0]   iBCD,
  output logic [BIN_W-1:0]      oBIN,
  output logic                  oDONE,
  output logic                  oBUSY,
  output logic                  oERR
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned WorkW = BcdW + BIN_W;
  localparam int unsigned CntW  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  // Counter value during the final step; the counter stops here rather than wrapping.
  localparam logic [CntW-1:0] CntLast = CntW'(BIN_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [WorkW-1:0]  r_work;
  logic [WorkW-1:0]  w_work_d;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_d;
  logic [BIN_W-1:0]  r_bin;
  logic [BIN_W-1:0]  w_bin_d;
  logic              r_done;
  logic              w_done_d;
  logic              r_busy;
  logic              w_busy_d;
  logic              r_err;
  logic              w_err_d;

  logic [WorkW-1:0]  w_step;
  logic              w_bad;

  // Any non-decimal digit on the input.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (iBCD[4*i +: 4] > 4'd9) begin
        w_bad = 1'b1;
      end
    end
  end

  // One conversion step: shift, then correct every BCD nibble in parallel.
  always_comb begin
    w_step = r_work >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_step[BIN_W+4*i +: 4] >= 4'd8) begin
        w_step[BIN_W+4*i +: 4] = w_step[BIN_W+4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_work_d  = r_work;
    w_cnt_d   = r_cnt;
    w_bin_d   = r_bin;
    w_err_d   = r_err;
    w_done_d  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (iSTART) begin
          if (w_bad) begin
            w_bin_d   = '0;
            w_err_d   = 1'b1;
            w_done_d  = 1'b1;
            w_state_d = StDone;
          end else begin
            w_work_d  = {iBCD, {BIN_W{1'b0}}};
            w_cnt_d   = '0;
            w_state_d = StConv;
          end
        end
      end
      StConv: begin
        w_work_d = w_step;
        if (r_cnt == CntLast) begin
          w_bin_d   = w_step[BIN_W-1:0];
          w_err_d   = 1'b0;
          w_done_d  = 1'b1;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Registered busy flag tracks the state being entered.
    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= StIdle;
      r_work  <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_work  <= w_work_d;
      r_cnt   <= w_cnt_d;
      r_bin   <= w_bin_d;
      r_done  <= w_done_d;
      r_busy  <= w_busy_d;
      r_err   <= w_err_d;
    end
  end

  assign oBIN  = r_bin;
  assign oDONE = r_done;
  assign oBUSY = r_busy;
  assign oERR  = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed bench for bcd2bin_seq at default parameters.
module tb_bcd2bin_seq;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;

  logic              iCLK_50;
  logic              iRST_N;
  logic              iSTART;
  logic [11:0]       iBCD;
  logic [BIN_W-1:0]  oBIN;
  logic              oDONE;
  logic              oBUSY;
  logic              oERR;

  int total;
  int bad;
  int cyc;

  bcd2bin_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) dut (
    .iCLK_50 (iCLK_50),
    .iRST_N  (iRST_N),
    .iSTART  (iSTART),
    .iBCD    (iBCD),
    .oBIN    (oBIN),
    .oDONE   (oDONE),
    .oBUSY   (oBUSY),
    .oERR    (oERR)
  );

  initial iCLK_50 = 1'b0;
  always #10 iCLK_50 = ~iCLK_50;

  initial cyc = 0;
  always @(posedge iCLK_50) cyc <= cyc + 1;

  task automatic tick();
    @(posedge iCLK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " done"}, 32'(oDONE), 32'd0);
    check({tag, " busy"}, 32'(oBUSY), 32'd0);
  endtask

  // Accept one request and follow it to completion. With disturb set, iSTART/iBCD are
  // scrambled while the conversion runs; the result must still match the accepted value.
  task automatic run_conv(input logic [11:0] bcd, input int exp_bin, input logic exp_err,
                          input bit disturb, input string tag);
    int lat;
    int busy_cnt;
    int exp_lat;
    exp_lat = exp_err ? 0 : BIN_W;
    iBCD   = bcd;
    iSTART = 1'b1;
    tick();
    iSTART   = 1'b0;
    lat      = 0;
    busy_cnt = oBUSY ? 1 : 0;
    while (!oDONE && lat < 30) begin
      if (disturb) begin
        iSTART = 1'($urandom_range(0, 1));
        iBCD   = 12'($urandom);
      end
      tick();
      lat++;
      if (oBUSY) busy_cnt++;
    end
    iSTART = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " bin"}, 32'(oBIN), 32'(exp_bin));
    check({tag, " err"}, 32'(oERR), 32'(exp_err));
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat + 1));
    tick();
    check_idle({tag, " after"});
    check({tag, " bin held"}, 32'(oBIN), 32'(exp_bin));
  endtask

  initial begin
    int q_done[$];
    int guard;
    logic [11:0] bcd;

    total  = 0;
    bad    = 0;
    iRST_N = 1'b0;
    iSTART = 1'b0;
    iBCD   = 12'h000;

    tick();
    tick();
    check("reset bin", 32'(oBIN), 32'd0);
    check("reset err", 32'(oERR), 32'd0);
    check_idle("reset");
    iRST_N = 1'b1;
    tick();
    tick();
    check("idle bin", 32'(oBIN), 32'd0);
    check("idle err", 32'(oERR), 32'd0);
    check_idle("idle");

    run_conv(12'h255, 255, 1'b0, 1'b0, "h255");
    tick();
    tick();
    check("h255 bin still held", 32'(oBIN), 32'd255);
    run_conv(12'h000, 0,   1'b0, 1'b0, "h000");
    run_conv(12'h999, 999, 1'b0, 1'b0, "h999");
    run_conv(12'h100, 100, 1'b0, 1'b0, "h100");
    run_conv(12'h1A3, 0,   1'b1, 1'b0, "h1A3 invalid");
    tick();
    check("err held", 32'(oERR), 32'd1);
    run_conv(12'h00A, 0,   1'b1, 1'b0, "h00A invalid");
    run_conv(12'h042, 42,  1'b0, 1'b0, "h042 after err");
    run_conv(12'h631, 631, 1'b0, 1'b1, "h631 disturbed");

    // Held-high start: accepts every BIN_W+2 cycles.
    iBCD   = 12'h321;
    iSTART = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (oDONE) begin
        q_done.push_back(cyc);
        check("held bin", 32'(oBIN), 32'd321);
      end
    end
    iSTART = 1'b0;
    check("held done count", 32'(q_done.size()), 32'd3);
    if (q_done.size() >= 3) begin
      check("held spacing 1", 32'(q_done[1] - q_done[0]), 32'(BIN_W + 2));
      check("held spacing 2", 32'(q_done[2] - q_done[1]), 32'(BIN_W + 2));
    end
    guard = 0;
    while (oBUSY && guard < 30) begin
      tick();
      guard++;
    end
    check("held drain", 32'(oBUSY), 32'd0);

    // Reset in the middle of a conversion.
    iBCD   = 12'h555;
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    check("pre-reset busy", 32'(oBUSY), 32'd1);
    iRST_N = 1'b0;
    #1;
    check("midreset bin", 32'(oBIN), 32'd0);
    check("midreset err", 32'(oERR), 32'd0);
    check_idle("midreset");
    for (int n = 0; n < 3; n++) begin
      tick();
      check("in reset done", 32'(oDONE), 32'd0);
    end
    iRST_N = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      check("post reset no done", 32'(oDONE), 32'd0);
    end
    run_conv(12'h087, 87, 1'b0, 1'b0, "h087 after reset");

    // Full decimal sweep with inputs scrambled while busy.
    for (int d2 = 0; d2 < 10; d2++) begin
      for (int d1 = 0; d1 < 10; d1++) begin
        for (int d0 = 0; d0 < 10; d0++) begin
          bcd = {4'(d2), 4'(d1), 4'(d0)};
          run_conv(bcd, d2 * 100 + d1 * 10 + d0, 1'b0, 1'b1,
                   $sformatf("sweep %03h", bcd));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
